special_tile_renderer: RTL and testbench

- Parametrised successor to the two-box +/- overlay drawer.
- Draws up to NUM_TILES square glyph tiles (plus, minus, blank, solid) onto the maze grid, one pixel per accepted cycle.
- Each tile has its own cell coordinates and enable bit. Pixel output is gated by a ready handshake from the VGA arbiter.
- Sits between the game-state logic and the VGA plot mux, alongside the other display modules.

---
 rtl/special_tile_renderer.sv | 169 ++++++++++++++++
 tb/tb_special_tile_renderer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/special_tile_renderer.sv
// Draws up to NUM_TILES square glyph tiles (plus/minus/blank/solid) onto the maze grid,
// one pixel per accepted cycle, with every output registered.
module special_tile_renderer #(
  parameter int unsigned NUM_TILES  = 2,
  parameter int unsigned COORD_W    = 5,
  parameter int unsigned LOC_W      = 9,
  parameter int unsigned TILE_SIZE  = 9,
  parameter int unsigned CELL_PITCH = 10,
  parameter int unsigned X_OFFSET   = 80,
  parameter int unsigned Y_OFFSET   = 0,
  parameter logic [2:0]  FG_PLUS    = 3'b100,
  parameter logic [2:0]  FG_MINUS   = 3'b010,
  parameter logic [2:0]  FG_SOLID   = 3'b001,
  parameter logic [2:0]  BG_COLOUR  = 3'b111
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [NUM_TILES*COORD_W-1:0] tile_x,
  input  logic [NUM_TILES*COORD_W-1:0] tile_y,
  input  logic [NUM_TILES*2-1:0]       tile_kind,
  input  logic [NUM_TILES-1:0]         tile_en,
  input  logic                         plot_ready,
  output logic [LOC_W-1:0]             xLoc,
  output logic [LOC_W-1:0]             yLoc,
  output logic [2:0]                   colour,
  output logic                         plot,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned SlotW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned B0    = TILE_SIZE / 3;
  localparam int unsigned B1    = TILE_SIZE - 1 - TILE_SIZE / 3;
  localparam logic [3:0]  Last  = 4'(TILE_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDraw, StNext, StDone} state_e;

  state_e                       state_q, state_d;
  logic [SlotW-1:0]             slot_q, slot_d, nxt_slot;
  logic [3:0]                   cx_q, cx_d, cy_q, cy_d;
  logic [NUM_TILES*COORD_W-1:0] tile_x_q, tile_y_q;
  logic [NUM_TILES*2-1:0]       kind_q;
  logic [NUM_TILES-1:0]         en_q;
  logic                         found, capture;
  logic [COORD_W-1:0]           tx, ty;
  logic [1:0]                   kind;
  logic                         hbar, vbar, plot_d;
  logic [LOC_W-1:0]             xloc_d, yloc_d;
  logic [2:0]                   colour_d;

  // Lowest enabled slot: from 0 in LOAD, strictly above the current slot otherwise.
  always_comb begin
    found    = 1'b0;
    nxt_slot = slot_q;
    for (int unsigned i = 0; i < NUM_TILES; i++) begin
      if (!found && en_q[i] && (state_q == StLoad || i > 32'(slot_q))) begin
        found    = 1'b1;
        nxt_slot = SlotW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad, StNext: begin
        cx_d = '0;
        cy_d = '0;
        if (found) begin
          slot_d  = nxt_slot;
          state_d = StDraw;
        end else begin
          state_d = StDone;
        end
      end
      StDraw: begin
        if (plot_ready) begin
          if (cx_q == Last) begin
            cx_d = '0;
            if (cy_q == Last) state_d = StNext;
            else              cy_d = cy_q + 4'd1;
          end else begin
            cx_d = cx_q + 4'd1;
          end
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!start && (state_q == StLoad || state_q == StDraw || state_q == StNext)) begin
      state_d = StIdle;
    end
  end

  // Pixel outputs are computed from next-state values so they register alongside the counters.
  always_comb begin
    plot_d   = (state_d == StDraw);
    tx       = tile_x_q[slot_d*COORD_W +: COORD_W];
    ty       = tile_y_q[slot_d*COORD_W +: COORD_W];
    kind     = kind_q[slot_d*2 +: 2];
    hbar     = (32'(cy_d) >= B0) && (32'(cy_d) <= B1) &&
               (32'(cx_d) >= 1) && (32'(cx_d) <= TILE_SIZE - 2);
    vbar     = (32'(cx_d) >= B0) && (32'(cx_d) <= B1) &&
               (32'(cy_d) >= 1) && (32'(cy_d) <= TILE_SIZE - 2);
    xloc_d   = '0;
    yloc_d   = '0;
    colour_d = '0;
    if (plot_d) begin
      xloc_d = LOC_W'(X_OFFSET + 32'(tx) * CELL_PITCH + 32'(cx_d));
      yloc_d = LOC_W'(Y_OFFSET + 32'(ty) * CELL_PITCH + 32'(cy_d));
      case (kind)
        2'b00:   colour_d = (hbar || vbar) ? FG_PLUS : BG_COLOUR;
        2'b01:   colour_d = hbar ? FG_MINUS : BG_COLOUR;
        2'b10:   colour_d = BG_COLOUR;
        default: colour_d = FG_SOLID;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
      kind_q   <= '0;
      en_q     <= '0;
      xLoc     <= '0;
      yLoc     <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      if (capture) begin
        tile_x_q <= tile_x;
        tile_y_q <= tile_y;
        kind_q   <= tile_kind;
        en_q     <= tile_en;
      end
      xLoc   <= xloc_d;
      yLoc   <= yloc_d;
      colour <= colour_d;
      plot   <= plot_d;
      busy   <= (state_d == StLoad) || (state_d == StDraw) || (state_d == StNext);
      done   <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_special_tile_renderer.sv
// Self-checking bench: pixel streams are compared against a queue built from the glyph rules.
module tb_special_tile_renderer;

  localparam int NT = 2, CW = 5, LW = 9, TS = 9, PITCH = 10, XO = 80, YO = 0;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [NT*CW-1:0]  tile_x = '0, tile_y = '0;
  logic [NT*2-1:0]   tile_kind = '0;
  logic [NT-1:0]     tile_en = '0;
  logic              plot_ready = 1'b0;
  logic [LW-1:0]     xLoc, yLoc;
  logic [2:0]        colour;
  logic              plot, busy, done;

  int n_checks = 0, n_fails = 0;
  logic [31:0] first_pix;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t exp_q[$];

  special_tile_renderer #(
    .NUM_TILES(NT), .COORD_W(CW), .LOC_W(LW), .TILE_SIZE(TS), .CELL_PITCH(PITCH),
    .X_OFFSET(XO), .Y_OFFSET(YO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .tile_x(tile_x), .tile_y(tile_y),
    .tile_kind(tile_kind), .tile_en(tile_en), .plot_ready(plot_ready),
    .xLoc(xLoc), .yLoc(yLoc), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int glyph(input int kind, input int cx, input int cy);
    int b0 = TS / 3;
    int b1 = TS - 1 - TS / 3;
    bit h = (cy >= b0) && (cy <= b1) && (cx >= 1) && (cx <= TS - 2);
    bit v = (cx >= b0) && (cx <= b1) && (cy >= 1) && (cy <= TS - 2);
    case (kind)
      0:       return (h || v) ? 4 : 7;
      1:       return h ? 2 : 7;
      2:       return 7;
      default: return 1;
    endcase
  endfunction

  function automatic int enabled_count();
    int e = 0;
    for (int s = 0; s < NT; s++) if (tile_en[s]) e++;
    return e;
  endfunction

  task automatic build_model();
    exp_q.delete();
    for (int s = 0; s < NT; s++) begin
      if (tile_en[s]) begin
        int tx = int'(tile_x[s*CW +: CW]);
        int ty = int'(tile_y[s*CW +: CW]);
        int k  = int'(tile_kind[s*2 +: 2]);
        for (int cy = 0; cy < TS; cy++)
          for (int cx = 0; cx < TS; cx++)
            exp_q.push_back('{(XO + tx * PITCH + cx) % (1 << LW),
                              (YO + ty * PITCH + cy) % (1 << LW), glyph(k, cx, cy)});
      end
    end
  endtask

  function automatic logic [31:0] pack(input int x, input int y, input int c);
    return {11'd0, x[LW-1:0], y[LW-1:0], c[2:0]};
  endfunction

  // Caller is at a negedge. mode: 0 ready held 1, 1 toggled, 2 random.
  task automatic run_draw(input int mode, input int abort_at, input string tag);
    int idx = 0, n = 0, done_n = -1;
    build_model();
    start = 1'b1;
    plot_ready = 1'b1;
    first_pix = '1;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      if (plot) begin
        check_eq({tag, "_in_range"}, 32'(idx < exp_q.size()), 32'd1);
        if (idx < exp_q.size()) begin
          check_eq({tag, "_pix"}, pack(int'(xLoc), int'(yLoc), int'(colour)),
                   pack(exp_q[idx].x, exp_q[idx].y, exp_q[idx].c));
          if (idx == 0 && first_pix == '1) first_pix = pack(int'(xLoc), int'(yLoc), int'(colour));
        end
      end
      if (done) begin
        done_n = n;
        break;
      end
      case (mode)
        0:       plot_ready = 1'b1;
        1:       plot_ready = ~plot_ready;
        default: plot_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (plot && plot_ready) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_abort_outs"}, {xLoc, yLoc, colour, plot, busy, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_eq({tag, "_abort_no_done"}, 32'(done), 32'd0);
        end
        return;
      end
      @(posedge clk);
      n++;
      if (n > 4000) begin
        check_eq({tag, "_timeout"}, 32'(n), 32'd0);
        break;
      end
    end
    check_eq({tag, "_accepted"}, 32'(idx), 32'(exp_q.size()));
    if (mode == 0 && done_n >= 0)
      check_eq({tag, "_done_cycle"}, 32'(done_n), 32'(1 + enabled_count() * (TS * TS + 1)));
    check_eq({tag, "_done_outs"}, {xLoc, yLoc, colour, plot, busy}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_hold"}, 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clk);
    check_eq({tag, "_idle"}, {xLoc, yLoc, colour, plot, busy, done}, 32'd0);
  endtask

  task automatic cfg_default(input logic [1:0] en);
    tile_x    = {5'd5, 5'd2};
    tile_y    = {5'd1, 5'd3};
    tile_kind = {2'b01, 2'b00};
    tile_en   = en;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("reset_outs", {xLoc, yLoc, colour, plot, busy, done}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", {xLoc, yLoc, colour, plot, busy, done}, 32'd0);

    cfg_default(2'b11);
    run_draw(0, -1, "s1");
    check_eq("s1_first", first_pix, pack(100, 30, 7));

    cfg_default(2'b10);
    run_draw(0, -1, "en10");
    check_eq("en10_first", first_pix, pack(130, 10, 7));

    cfg_default(2'b00);
    run_draw(0, -1, "en00");

    cfg_default(2'b11);
    run_draw(1, -1, "toggle");

    run_draw(0, 40, "abort");
    run_draw(0, -1, "restart");
    check_eq("restart_first", first_pix, pack(100, 30, 7));

    // Asynchronous reset in the middle of a tile.
    start = 1'b1;
    plot_ready = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rst_in_draw", 32'(plot), 32'd1);
    #2 resetn = 1'b0;
    #1 check_eq("rst_async_outs", {xLoc, yLoc, colour, plot, busy, done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_draw(0, -1, "after_rst");
    check_eq("after_rst_first", first_pix, pack(100, 30, 7));

    for (int it = 0; it < 6; it++) begin
      tile_x    = NT*CW'($urandom);
      tile_y    = NT*CW'($urandom);
      tile_kind = NT*2'($urandom);
      tile_en   = NT'($urandom);
      run_draw((it % 2 == 0) ? 2 : 0, -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
